lut_dp_bank: RTL and testbench
==============================

Name: lut_dp_bank

Overview:
- Parametrised dual-port lookup/coefficient memory for the matrix-vector multiply datapath.
- Successor to the single-port registered-read LUT.
- Port A: read/write, used by the loader and preprocessor. Port B: read-only, used by the MAC lane.
- Adds valid-tagged reads, selectable read-during-write mode, an optional output pipeline stage, A/B collision detection and a self-timed memory clear sequencer.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_BITS, 8, address width; DEPTH = 2**ADDR_BITS.
- INIT_FILE, "", binary image loaded with $readmemb over 0..DEPTH-1; empty string means no load.
- RDW_MODE, 0, port A read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
- OUT_REG, 0, 1 adds an output register stage to both ports (+1 cycle latency).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- a_en  in  1  port A access request.
- a_we  in  1  port A write qualifier (valid only with a_en).
- a_addr  in  ADDR_BITS  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_rvalid  out  1  a_rdata valid, one-cycle pulse per accepted access.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_BITS  port B address.
- b_rdata  out  DATA_WIDTH  port B read data.
- b_rvalid  out  1  b_rdata valid.
- b_collide  out  1  port B read hit the address port A wrote in the same cycle; aligned with b_rvalid.
- clr_start  in  1  start memory clear (level sampled).
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (synchronous, active-high):
  - a_rdata, b_rdata, a_rvalid, b_rvalid, b_collide, clr_busy, clr_done all go to 0.
  - FSM goes to IDLE and the clear counter goes to 0.
  - Memory array is not reset; INIT_FILE contents persist until written.
- Latency: read data and rvalid appear L = 1 + OUT_REG cycles after the request edge. Fully pipelined, one access per port per cycle, no backpressure.
- Reads without a_en/b_en: rdata holds its previous value, rvalid = 0.
- Port A write (a_en & a_we):
  - Memory updated at the edge.
  - a_rvalid still pulses.
  - a_rdata = old word if RDW_MODE=0, a_wdata if RDW_MODE=1.
- Port B, same cycle as a port A write to the same address:
  - b_rdata returns the old word regardless of RDW_MODE.
  - b_collide = 1 with that b_rvalid; otherwise 0.
- Port B never writes.
- FSM IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE: clr_start = 1 moves to CLEAR with counter = 0.
  - CLEAR:
    - Writes 0 to address counter each cycle via port A; clr_busy = 1.
    - Counter increments; after writing address DEPTH-1 (no wrap), moves to DONE.
    - Clear occupies exactly DEPTH cycles.
  - DONE: clr_done = 1 for one cycle, clr_busy = 0, then IDLE.
- During CLEAR:
  - a_en and b_en requests are dropped: no memory effect, rvalid stays 0.
  - clr_start is ignored.
- clr_start asserted in the DONE cycle: ignored. It must be re-sampled in IDLE, so a held clr_start restarts one cycle after DONE.
- Reset mid-clear: aborts immediately. Already-cleared addresses stay 0, the rest keep prior data, no clr_done pulse.
- Pipeline and reset: with OUT_REG=1, rst kills in-flight reads, so no rvalid emerges after reset.
- Width rules: addresses are unsigned; the clear counter is ADDR_BITS+1 wide to detect the terminal count.

Test Plan:
- Init load: INIT_FILE with word[5]=16'h00A5, rst, b_en addr 5 -> b_rdata=16'h00A5, b_rvalid high exactly 1 cycle later (2 with OUT_REG=1).
- RDW mode: mem[3]=16'h1111, A writes 16'h2222 to 3 -> a_rdata=16'h1111 (RDW_MODE=0) or 16'h2222 (RDW_MODE=1). The following read returns 16'h2222 in both modes.
- Collision: same cycle, A writes 16'hBEEF to 7 and B reads 7 (old 16'h0007) -> b_rdata=16'h0007, b_collide=1. B reading 8 instead -> b_collide=0.
- Clear: ADDR_BITS=4, pulse clr_start -> clr_busy high 16 cycles, clr_done 1-cycle pulse, all 16 addresses read 0. A/B requests issued during busy give no rvalid and do not alter memory.
- Reset mid-clear: ADDR_BITS=4, all words 16'hFFFF, rst after 6 CLEAR cycles -> addresses 0-5 read 0, 6-15 read 16'hFFFF, clr_done never pulses.
- Back-to-back streaming: B reads addresses 0..255 on consecutive cycles -> 256 consecutive b_rvalid pulses with matching data, no bubbles.

Source files
------------

// File: rtl/lut_dp_bank.sv
// Dual-port coefficient memory: port A read/write, port B read-only, valid-tagged
// registered reads, optional output stage, A/B collision flag and a self-timed clear.
module lut_dp_bank #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_BITS  = 8,
    parameter string INIT_FILE  = "",
    parameter int    RDW_MODE   = 0,
    parameter int    OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_BITS-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic [ADDR_BITS-1:0]  b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  b_collide,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_BITS:0]    cnt_q, cnt_d;

    logic                  clearing;
    logic                  a_acc;
    logic                  b_acc;
    logic                  wr_en;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0] a_rdata1_q, a_rdata1_d;
    logic [DATA_WIDTH-1:0] b_rdata1_q, b_rdata1_d;
    logic                  a_rvalid1_q, a_rvalid1_d;
    logic                  b_rvalid1_q, b_rvalid1_d;
    logic                  b_collide1_q, b_collide1_d;

    // User requests are dropped while the sequencer owns the write port.
    assign clearing = (state_q == ST_CLEAR);
    assign a_acc    = a_en & ~clearing;
    assign b_acc    = b_en & ~clearing;
    assign wr_en    = ~rst & (clearing | (a_acc & a_we));
    assign wr_addr  = clearing ? cnt_q[ADDR_BITS-1:0] : a_addr;
    assign wr_data  = clearing ? '0 : a_wdata;

    assign clr_busy = clearing;
    assign clr_done = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                // Carry into the extra bit marks the write of the last address.
                if (cnt_d[ADDR_BITS]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_rdata1_d   = a_rdata1_q;
        b_rdata1_d   = b_rdata1_q;
        a_rvalid1_d  = a_acc;
        b_rvalid1_d  = b_acc;
        b_collide1_d = b_acc & a_acc & a_we & (a_addr == b_addr);
        if (a_acc) begin
            a_rdata1_d = ((RDW_MODE == 1) && a_we) ? a_wdata : mem[a_addr];
        end
        // Port B always sees the pre-write word, even on a collision.
        if (b_acc) begin
            b_rdata1_d = mem[b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_rdata1_q   <= '0;
            b_rdata1_q   <= '0;
            a_rvalid1_q  <= 1'b0;
            b_rvalid1_q  <= 1'b0;
            b_collide1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_rdata1_q   <= a_rdata1_d;
            b_rdata1_q   <= b_rdata1_d;
            a_rvalid1_q  <= a_rvalid1_d;
            b_rvalid1_q  <= b_rvalid1_d;
            b_collide1_q <= b_collide1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] a_rdata2_q, a_rdata2_d;
            logic [DATA_WIDTH-1:0] b_rdata2_q, b_rdata2_d;
            logic                  a_rvalid2_q, b_rvalid2_q, b_collide2_q;

            always_comb begin
                a_rdata2_d = a_rvalid1_q ? a_rdata1_q : a_rdata2_q;
                b_rdata2_d = b_rvalid1_q ? b_rdata1_q : b_rdata2_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_rdata2_q   <= '0;
                    b_rdata2_q   <= '0;
                    a_rvalid2_q  <= 1'b0;
                    b_rvalid2_q  <= 1'b0;
                    b_collide2_q <= 1'b0;
                end else begin
                    a_rdata2_q   <= a_rdata2_d;
                    b_rdata2_q   <= b_rdata2_d;
                    a_rvalid2_q  <= a_rvalid1_q;
                    b_rvalid2_q  <= b_rvalid1_q;
                    b_collide2_q <= b_collide1_q;
                end
            end

            assign a_rdata   = a_rdata2_q;
            assign b_rdata   = b_rdata2_q;
            assign a_rvalid  = a_rvalid2_q;
            assign b_rvalid  = b_rvalid2_q;
            assign b_collide = b_collide2_q;
        end else begin : g_direct
            assign a_rdata   = a_rdata1_q;
            assign b_rdata   = b_rdata1_q;
            assign a_rvalid  = a_rvalid1_q;
            assign b_rvalid  = b_rvalid1_q;
            assign b_collide = b_collide1_q;
        end
    endgenerate

endmodule

// File: tb/tb_lut_dp_bank.sv
// Two lut_dp_bank copies (read-first/direct and write-first/registered) driven in lockstep
// and compared every cycle against a per-edge behavioural model.
module tb_lut_dp_bank;

    localparam int DW    = 16;
    localparam int AB    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_en, a_we, b_en, clr_start;
    logic [AB-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata;

    logic [DW-1:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
    logic          a_rvalid0, b_rvalid0, b_collide0, clr_busy0, clr_done0;
    logic          a_rvalid1, b_rvalid1, b_collide1, clr_busy1, clr_done1;

    always #5 clk = ~clk;

    lut_dp_bank #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .INIT_FILE(""), .RDW_MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
        .b_collide(b_collide0),
        .clr_start(clr_start), .clr_busy(clr_busy0), .clr_done(clr_done0)
    );

    lut_dp_bank #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .INIT_FILE(""), .RDW_MODE(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .b_collide(b_collide1),
        .clr_start(clr_start), .clr_busy(clr_busy1), .clr_done(clr_done1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: memory contents, clear progress and expected port outputs.
    typedef struct packed {
        logic          v;
        logic          c;
        logic [DW-1:0] d;
    } res_t;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_state;      // 0 idle, 1 clearing, 2 done
    int            m_clr_idx;
    res_t          e_a0, e_b0, e_a1, e_b1;
    res_t          p_a1, p_b1;   // reads still inside the extra output stage

    int busy_cnt, done_cnt, bval0_cnt, bval1_cnt, coll_cnt;

    function automatic void model_edge();
        res_t ra0, ra1, rb;
        bit   clearing;
        if (rst) begin
            m_state   = 0;
            m_clr_idx = 0;
            e_a0 = '0; e_b0 = '0; e_a1 = '0; e_b1 = '0;
            p_a1 = '0; p_b1 = '0;
            return;
        end
        clearing = (m_state == 1);
        ra0 = '0; ra1 = '0; rb = '0;
        if (a_en && !clearing) begin
            ra0.v = 1'b1;
            ra1.v = 1'b1;
            ra0.d = m_mem[a_addr];
            ra1.d = a_we ? a_wdata : m_mem[a_addr];
        end
        if (b_en && !clearing) begin
            rb.v = 1'b1;
            rb.d = m_mem[b_addr];
            rb.c = a_en && a_we && (a_addr == b_addr);
        end
        e_a0.v = ra0.v; if (ra0.v) e_a0.d = ra0.d;
        e_b0.v = rb.v;  e_b0.c = rb.c; if (rb.v) e_b0.d = rb.d;
        e_a1.v = p_a1.v; if (p_a1.v) e_a1.d = p_a1.d;
        e_b1.v = p_b1.v; e_b1.c = p_b1.c; if (p_b1.v) e_b1.d = p_b1.d;
        p_a1 = ra1;
        p_b1 = rb;
        case (m_state)
            1: begin
                m_mem[m_clr_idx] = '0;
                m_clr_idx++;
                if (m_clr_idx == DEPTH) m_state = 2;
            end
            2: m_state = 0;
            default: begin
                if (clr_start) begin
                    m_state   = 1;
                    m_clr_idx = 0;
                end
            end
        endcase
        if (!clearing && a_en && a_we) m_mem[a_addr] = a_wdata;
    endfunction

    task automatic check_outputs();
        chk_val("a_rvalid0",  32'(a_rvalid0),  32'(e_a0.v));
        chk_val("a_rdata0",   32'(a_rdata0),   32'(e_a0.d));
        chk_val("b_rvalid0",  32'(b_rvalid0),  32'(e_b0.v));
        chk_val("b_rdata0",   32'(b_rdata0),   32'(e_b0.d));
        chk_val("b_collide0", 32'(b_collide0), 32'(e_b0.v & e_b0.c));
        chk_val("clr_busy0",  32'(clr_busy0),  32'(m_state == 1));
        chk_val("clr_done0",  32'(clr_done0),  32'(m_state == 2));
        chk_val("a_rvalid1",  32'(a_rvalid1),  32'(e_a1.v));
        chk_val("a_rdata1",   32'(a_rdata1),   32'(e_a1.d));
        chk_val("b_rvalid1",  32'(b_rvalid1),  32'(e_b1.v));
        chk_val("b_rdata1",   32'(b_rdata1),   32'(e_b1.d));
        chk_val("b_collide1", 32'(b_collide1), 32'(e_b1.v & e_b1.c));
        chk_val("clr_busy1",  32'(clr_busy1),  32'(m_state == 1));
        chk_val("clr_done1",  32'(clr_done1),  32'(m_state == 2));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        busy_cnt  += int'(clr_busy0) + int'(clr_busy1);
        done_cnt  += int'(clr_done0) + int'(clr_done1);
        bval0_cnt += int'(b_rvalid0);
        bval1_cnt += int'(b_rvalid1);
        coll_cnt  += int'(b_collide0);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; clr_start = 1'b0;
    endtask

    task automatic wr_a(input logic [AB-1:0] addr, input logic [DW-1:0] data);
        a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
        cycle();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1; a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; clr_start = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0;
        m_state = 0; m_clr_idx = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        e_a0 = '0; e_b0 = '0; e_a1 = '0; e_b1 = '0; p_a1 = '0; p_b1 = '0;
        busy_cnt = 0; done_cnt = 0; bval0_cnt = 0; bval1_cnt = 0; coll_cnt = 0;

        cycle(); cycle();
        idle_inputs();
        cycle();

        // Clear with requests hammering low addresses while busy.
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1; cycle(); clr_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a_en = 1'($urandom_range(0, 1)); a_we = 1'b1;
            a_addr = AB'($urandom_range(0, 3)); a_wdata = 16'hDEAD;
            b_en = 1'b1; b_addr = AB'($urandom);
            cycle();
        end
        idle_inputs(); cycle(); cycle();
        chk_val("clear_busy_cycles", 32'(busy_cnt), 32'(2 * DEPTH));
        chk_val("clear_done_pulses", 32'(done_cnt), 32'd2);
        for (int i = 0; i < DEPTH; i++) begin
            a_en = 1'b1; a_we = 1'b0; a_addr = AB'(i);
            b_en = 1'b1; b_addr = AB'(DEPTH - 1 - i);
            cycle();
        end
        idle_inputs(); cycle(); cycle();

        // Read-during-write on port A.
        wr_a(4'd3, 16'h1111);
        wr_a(4'd3, 16'h2222);
        a_en = 1'b1; a_addr = 4'd3; cycle();
        idle_inputs(); cycle(); cycle();

        // Collision on the same address, then a near miss.
        wr_a(4'd7, 16'h0007);
        wr_a(4'd8, 16'h0008);
        coll_cnt = 0;
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 16'hBEEF; b_en = 1'b1; b_addr = 4'd7;
        cycle();
        a_wdata = 16'hCAFE; b_addr = 4'd8;
        cycle();
        idle_inputs(); cycle(); cycle();
        chk_val("collide_pulses", 32'(coll_cnt), 32'd1);

        // Reset after six clear cycles.
        for (int i = 0; i < DEPTH; i++) wr_a(AB'(i), 16'hFFFF);
        done_cnt = 0;
        clr_start = 1'b1; cycle(); clr_start = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        cycle(); cycle(); cycle();
        chk_val("abort_done_pulses", 32'(done_cnt), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            b_en = 1'b1; b_addr = AB'(i);
            cycle();
            chk_val("abort_word", 32'(b_rdata0), (i < 6) ? 32'h0 : 32'hFFFF);
        end
        idle_inputs(); cycle(); cycle();

        // Held clr_start restarts only after passing back through idle.
        done_cnt = 0;
        clr_start = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk_val("held_start_done_pulses", 32'(done_cnt), 32'd6);

        // Back-to-back streaming on port B.
        bval0_cnt = 0; bval1_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            b_en = 1'b1; b_addr = AB'(i % DEPTH);
            a_en = 1'b1; a_we = 1'b0; a_addr = AB'(i);
            cycle();
        end
        idle_inputs(); cycle(); cycle();
        chk_val("stream_bvalid0", 32'(bval0_cnt), 32'd64);
        chk_val("stream_bvalid1", 32'(bval1_cnt), 32'd64);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            clr_start = ($urandom_range(0, 79) == 0);
            a_en      = 1'($urandom_range(0, 1));
            a_we      = 1'($urandom_range(0, 1));
            a_addr    = AB'($urandom);
            a_wdata   = DW'($urandom);
            b_en      = 1'($urandom_range(0, 1));
            b_addr    = ($urandom_range(0, 3) == 0) ? a_addr : AB'($urandom);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
